// File: rtl/ser_par_pkg.sv
// Shared constants for the serial-to-parallel datapath blocks.
package ser_par_pkg;

  // FSM state encodings.
  localparam logic [0:0] ST_HUNT    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

  // Start code shared with the legacy fixed 0x5A detector.
  localparam logic [7:0] DEFAULT_SYNC_WORD = 8'h5A;

  // Counter width that never collapses to zero bits for small counts.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_word_matcher.sv
// Sync word hunter: bit history, saturating fill counter and comparator.
module sync_word_matcher
  import ser_par_pkg::*;
#(
  parameter int unsigned           SYNC_W    = 8,
  parameter logic [SYNC_W-1:0]     SYNC_WORD = SYNC_W'(DEFAULT_SYNC_WORD)
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  input  logic bit_in,
  input  logic bit_en,
  output logic match
);

  localparam int unsigned       FILL_W    = $clog2(SYNC_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SYNC_W);

  logic [SYNC_W-1:0] hist_q, hist_d, hist_shift;
  logic [FILL_W-1:0] fill_q, fill_d, fill_shift;

  // Match is evaluated on the post-shift history so lock costs no extra cycle.
  always_comb begin
    hist_shift = {hist_q[SYNC_W-2:0], bit_in};
    fill_shift = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
    match      = bit_en && (fill_shift == FILL_FULL) && (hist_shift == SYNC_WORD);
    hist_d     = bit_en ? hist_shift : hist_q;
    if (clear) begin
      fill_d = '0;
    end else if (bit_en) begin
      fill_d = fill_shift;
    end else begin
      fill_d = fill_q;
    end
  end

  // History and fill registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/sync_word_deserializer.sv
// Sync-word gated serial-to-parallel converter: hunt for sync, then
// deserialise FRAME_WORDS words of DATA_W bits and return to hunting.
module sync_word_deserializer
  import ser_par_pkg::*;
#(
  parameter int unsigned       SYNC_W      = 8,
  parameter logic [SYNC_W-1:0] SYNC_WORD   = SYNC_W'(DEFAULT_SYNC_WORD),
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       FRAME_WORDS = 4,
  parameter bit                MSB_FIRST   = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              S_IN,
  input  logic              S_VALID,
  output logic [DATA_W-1:0] P_OUT,
  output logic              P_VALID,
  output logic              FRAME_START,
  output logic              FRAME_END,
  output logic              LOCKED
);

  localparam int unsigned       BIT_W     = $clog2(DATA_W);
  localparam int unsigned       WORD_W    = width_of(FRAME_WORDS);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(FRAME_WORDS - 1);

  logic [0:0]        state_q, state_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [DATA_W-1:0] data_q, data_d, data_shift;
  logic [DATA_W-1:0] pout_q, pout_d;
  logic              pv_q, pv_d, fs_q, fs_d, fe_q, fe_d, lock_q, lock_d;
  logic              hunt_en, take, match, end_frame;

  assign hunt_en = S_VALID && (state_q == ST_HUNT);
  assign take    = S_VALID && (state_q == ST_COLLECT);

  sync_word_matcher #(
    .SYNC_W    (SYNC_W),
    .SYNC_WORD (SYNC_WORD)
  ) u_matcher (
    .CLK    (CLK),
    .RESET  (RESET),
    .clear  (match | end_frame),
    .bit_in (S_IN),
    .bit_en (hunt_en),
    .match  (match)
  );

  // Next-state: lock on match, assemble words, leave COLLECT after the last word.
  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    word_d     = word_q;
    data_d     = data_q;
    pout_d     = pout_q;
    pv_d       = 1'b0;
    fs_d       = 1'b0;
    fe_d       = 1'b0;
    end_frame  = 1'b0;
    // LOCKED is its own register so it drops one edge after FRAME_END,
    // while the FSM is already back in HUNT on that edge.
    lock_d     = fe_q ? 1'b0 : lock_q;
    data_shift = MSB_FIRST ? {data_q[DATA_W-2:0], S_IN} : {S_IN, data_q[DATA_W-1:1]};
    if (match) begin
      state_d = ST_COLLECT;
      bit_d   = '0;
      word_d  = '0;
      lock_d  = 1'b1;
    end
    if (take) begin
      data_d = data_shift;
      bit_d  = bit_q + BIT_W'(1);
      if (bit_q == BIT_LAST) begin
        bit_d  = '0;
        pout_d = data_shift;
        pv_d   = 1'b1;
        fs_d   = (word_q == '0);
        fe_d   = (word_q == WORD_LAST);
        word_d = word_q + WORD_W'(1);
        if (word_q == WORD_LAST) begin
          end_frame = 1'b1;
          state_d   = ST_HUNT;
          word_d    = '0;
        end
      end
    end
  end

  // State, counters, data and output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_HUNT;
      bit_q   <= '0;
      word_q  <= '0;
      data_q  <= '0;
      pout_q  <= '0;
      pv_q    <= 1'b0;
      fs_q    <= 1'b0;
      fe_q    <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      data_q  <= data_d;
      pout_q  <= pout_d;
      pv_q    <= pv_d;
      fs_q    <= fs_d;
      fe_q    <= fe_d;
      lock_q  <= lock_d;
    end
  end

  assign P_OUT       = pout_q;
  assign P_VALID     = pv_q;
  assign FRAME_START = fs_q;
  assign FRAME_END   = fe_q;
  assign LOCKED      = lock_q;

endmodule

// File: tb/tb_sync_word_deserializer.sv
// Bench for sync_word_deserializer: a default instance (A) and a
// 12-bit, LSB-first, single-word instance (B) share one input stream.
module tb_sync_word_deserializer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1, S_IN = 1'b0, S_VALID = 1'b0;
  logic [7:0]  a_pout;
  logic [11:0] b_pout;
  logic        a_pv, a_fs, a_fe, a_lk, b_pv, b_fs, b_fe, b_lk;
  logic [15:0] got_a, got_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  sync_word_deserializer dut_a (
    .CLK(CLK), .RESET(RESET), .S_IN(S_IN), .S_VALID(S_VALID),
    .P_OUT(a_pout), .P_VALID(a_pv), .FRAME_START(a_fs), .FRAME_END(a_fe), .LOCKED(a_lk)
  );

  sync_word_deserializer #(
    .SYNC_W(8), .SYNC_WORD(8'h5A), .DATA_W(12), .FRAME_WORDS(1), .MSB_FIRST(1'b0)
  ) dut_b (
    .CLK(CLK), .RESET(RESET), .S_IN(S_IN), .S_VALID(S_VALID),
    .P_OUT(b_pout), .P_VALID(b_pv), .FRAME_START(b_fs), .FRAME_END(b_fe), .LOCKED(b_lk)
  );

  assign got_a = {a_lk, a_pv, a_fs, a_fe, 4'h0, a_pout};
  assign got_b = {b_lk, b_pv, b_fs, b_fe, b_pout};

  // Reference model: per instance, a hunting/collecting flag, sync history,
  // a list of collected data bits and the expected registered outputs.
  int unsigned DW[2] = '{8, 12};
  int unsigned FW[2] = '{4, 1};
  bit          MSBF[2] = '{1'b1, 1'b0};
  bit          m_coll[2];
  int unsigned m_hist[2], m_fill[2], m_nb[2], m_wc[2];
  bit          m_bits[2][12];
  int unsigned e_pout[2];
  bit          e_pv[2], e_fs[2], e_fe[2], e_lk[2];

  task automatic model_edge(input bit r, input bit v, input bit s);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        m_coll[i] = 0; m_hist[i] = 0; m_fill[i] = 0; m_nb[i] = 0; m_wc[i] = 0;
        e_pout[i] = 0; e_pv[i] = 0; e_fs[i] = 0; e_fe[i] = 0; e_lk[i] = 0;
      end else begin
        if (e_fe[i]) e_lk[i] = 0;
        e_pv[i] = 0; e_fs[i] = 0; e_fe[i] = 0;
        if (v) begin
          if (!m_coll[i]) begin
            m_hist[i] = ((m_hist[i] << 1) | int'(s)) & 32'hFF;
            if (m_fill[i] < 8) m_fill[i]++;
            if (m_fill[i] == 8 && m_hist[i] == 32'h5A) begin
              m_coll[i] = 1; e_lk[i] = 1; m_nb[i] = 0; m_wc[i] = 0; m_fill[i] = 0;
            end
          end else begin
            m_bits[i][m_nb[i]] = s;
            m_nb[i]++;
            if (m_nb[i] == DW[i]) begin
              int unsigned w;
              w = 0;
              for (int j = 0; j < int'(DW[i]); j++)
                if (m_bits[i][j]) w += MSBF[i] ? (1 << (DW[i] - 1 - j)) : (1 << j);
              e_pout[i] = w; e_pv[i] = 1;
              e_fs[i] = (m_wc[i] == 0);
              e_fe[i] = (m_wc[i] == FW[i] - 1);
              m_nb[i] = 0;
              m_wc[i]++;
              if (e_fe[i]) begin
                m_coll[i] = 0; m_wc[i] = 0; m_fill[i] = 0;
              end
            end
          end
        end
      end
    end
  endtask

  function automatic logic [15:0] exp_vec(input int i);
    return {e_lk[i], e_pv[i], e_fs[i], e_fe[i], 12'(e_pout[i])};
  endfunction

  // One clock with the given inputs; outputs are settled #1 after the edge.
  task automatic step(input bit r, input bit v, input bit s);
    RESET = r; S_VALID = v; S_IN = s;
    @(posedge CLK);
    model_edge(r, v, s);
    #1;
  endtask

  bit stim[$];
  task automatic add_byte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) stim.push_back(b[k]);
  endtask

  task automatic test_reset;
    step(1, 1, 1);
    step(1, 0, 0);
    n_cmp++;
    if (got_a !== 16'h0000) begin n_bad++; $display("FAIL reset_a: got %h exp 0000", got_a); end
    n_cmp++;
    if (got_b !== 16'h0000) begin n_bad++; $display("FAIL reset_b: got %h exp 0000", got_b); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] words[$];
    int         pos[$];
    logic [7:0] want[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    step(1, 0, 0);
    stim.delete();
    add_byte(8'h5A); add_byte(8'h11); add_byte(8'h22); add_byte(8'h33); add_byte(8'h44);
    for (int k = 0; k < stim.size(); k++) begin
      step(0, 1, stim[k]);
      n_cmp++;
      if (got_a !== exp_vec(0)) begin n_bad++; $display("FAIL b2b_model_a k=%0d: got %h exp %h", k, got_a, exp_vec(0)); end
      n_cmp++;
      if (got_b !== exp_vec(1)) begin n_bad++; $display("FAIL b2b_model_b k=%0d: got %h exp %h", k, got_b, exp_vec(1)); end
      if (k == 6 || k == 7) begin
        n_cmp++;
        if (a_lk !== (k == 7)) begin n_bad++; $display("FAIL b2b_lock k=%0d: got %b exp %b", k, a_lk, k == 7); end
      end
      if (a_pv === 1'b1) begin
        words.push_back(a_pout); pos.push_back(k);
        n_cmp++;
        if ({a_fs, a_fe} !== {words.size() == 1, words.size() == 4}) begin
          n_bad++; $display("FAIL b2b_flags word=%0d: got fs=%b fe=%b", words.size(), a_fs, a_fe);
        end
      end
    end
    n_cmp++;
    if (words.size() != 4) begin n_bad++; $display("FAIL b2b_count: got %0d exp 4", words.size()); end
    for (int j = 0; j < words.size() && j < 4; j++) begin
      n_cmp++;
      if (words[j] !== want[j] || pos[j] != 15 + 8 * j) begin
        n_bad++; $display("FAIL b2b_word%0d: got %h at %0d exp %h at %0d", j, words[j], pos[j], want[j], 15 + 8 * j);
      end
    end
    step(0, 0, 0);
    n_cmp++;
    if (a_lk !== 1'b0) begin n_bad++; $display("FAIL b2b_unlock: got %b exp 0", a_lk); end
  endtask

  task automatic test_overlap;
    int rises = 0, at = -1;
    logic prev = 1'b0;
    step(1, 0, 0);
    stim.delete();
    repeat (10) stim.push_back(1'b1);
    add_byte(8'h55); add_byte(8'hA0);
    for (int k = 0; k < 22; k++) begin
      step(0, 1, stim[k]);
      n_cmp++;
      if (got_a !== exp_vec(0)) begin n_bad++; $display("FAIL overlap_model_a k=%0d: got %h exp %h", k, got_a, exp_vec(0)); end
      if (a_lk && !prev) begin rises++; at = k; end
      prev = a_lk;
    end
    n_cmp++;
    if (rises != 1 || at != 21) begin n_bad++; $display("FAIL overlap_lock: got %0d rises at %0d exp 1 at 21", rises, at); end
  endtask

  task automatic test_gated;
    logic [7:0] words[$];
    logic [7:0] want[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int         idx = 0, cyc = 0;
    bit         v;
    step(1, 0, 0);
    stim.delete();
    add_byte(8'h5A); add_byte(8'h11); add_byte(8'h22); add_byte(8'h33); add_byte(8'h44);
    while (idx < stim.size() && cyc < 500) begin
      v = (cyc % 3 == 0);
      step(0, v, v ? stim[idx] : 1'($urandom_range(0, 1)));
      if (v) idx++;
      cyc++;
      n_cmp++;
      if (got_a !== exp_vec(0)) begin n_bad++; $display("FAIL gated_model_a c=%0d: got %h exp %h", cyc, got_a, exp_vec(0)); end
      n_cmp++;
      if (got_b !== exp_vec(1)) begin n_bad++; $display("FAIL gated_model_b c=%0d: got %h exp %h", cyc, got_b, exp_vec(1)); end
      if (!v) begin
        n_cmp++;
        if ({a_pv, a_fs, a_fe} !== 3'b000) begin n_bad++; $display("FAIL gated_idle_pulse c=%0d: got %b exp 000", cyc, {a_pv, a_fs, a_fe}); end
      end
      if (a_pv === 1'b1) words.push_back(a_pout);
    end
    n_cmp++;
    if (words.size() != 4) begin n_bad++; $display("FAIL gated_count: got %0d exp 4", words.size()); end
    for (int j = 0; j < words.size() && j < 4; j++) begin
      n_cmp++;
      if (words[j] !== want[j]) begin n_bad++; $display("FAIL gated_word%0d: got %h exp %h", j, words[j], want[j]); end
    end
  endtask

  task automatic test_mid_reset;
    step(1, 0, 0);
    stim.delete();
    add_byte(8'h5A); add_byte(8'h11); add_byte(8'h22);
    foreach (stim[k]) step(0, 1, stim[k]);
    n_cmp++;
    if ({a_lk, a_pv, a_pout} !== {1'b1, 1'b1, 8'h22}) begin n_bad++; $display("FAIL midrst_pre: got lk=%b pv=%b %h exp 1 1 22", a_lk, a_pv, a_pout); end
    step(1, 1, 1);
    n_cmp++;
    if (got_a !== 16'h0000) begin n_bad++; $display("FAIL midrst_a: got %h exp 0000", got_a); end
    stim.delete();
    add_byte(8'h33);
    foreach (stim[k]) begin
      step(0, 1, stim[k]);
      n_cmp++;
      if (got_a !== 16'h0000) begin n_bad++; $display("FAIL midrst_after k=%0d: got %h exp 0000", k, got_a); end
      n_cmp++;
      if (got_a !== exp_vec(0)) begin n_bad++; $display("FAIL midrst_model_a k=%0d: got %h exp %h", k, got_a, exp_vec(0)); end
    end
  endtask

  task automatic test_lsb12;
    logic [11:0] d = 12'hABC;
    step(1, 0, 0);
    stim.delete();
    add_byte(8'h5A);
    for (int j = 0; j < 12; j++) stim.push_back(d[j]);
    for (int k = 0; k < stim.size(); k++) begin
      step(0, 1, stim[k]);
      n_cmp++;
      if (got_b !== exp_vec(1)) begin n_bad++; $display("FAIL lsb12_model_b k=%0d: got %h exp %h", k, got_b, exp_vec(1)); end
    end
    n_cmp++;
    if ({b_pv, b_fs, b_fe, b_pout} !== {3'b111, 12'hABC}) begin
      n_bad++; $display("FAIL lsb12_word: got %b%b%b %h exp 111 abc", b_pv, b_fs, b_fe, b_pout);
    end
  endtask

  task automatic test_relock;
    int   rises[$];
    logic prev = 1'b0;
    step(1, 0, 0);
    stim.delete();
    add_byte(8'h5A); add_byte(8'h11); add_byte(8'h22); add_byte(8'h33); add_byte(8'h5A);
    add_byte(8'h00); add_byte(8'h5A);
    for (int k = 0; k < stim.size(); k++) begin
      step(0, 1, stim[k]);
      n_cmp++;
      if (got_a !== exp_vec(0)) begin n_bad++; $display("FAIL relock_model_a k=%0d: got %h exp %h", k, got_a, exp_vec(0)); end
      if (a_lk && !prev) rises.push_back(k);
      prev = a_lk;
    end
    n_cmp++;
    if (rises.size() != 2 || rises[0] != 7 || rises[rises.size()-1] != 55) begin
      n_bad++; $display("FAIL relock_rises: got %0d rises exp 2 at 7 and 55", rises.size());
    end
  endtask

  task automatic test_random;
    bit src[$];
    bit r, v, s;
    logic [7:0] b;
    step(1, 0, 0);
    for (int c = 0; c < 4000; c++) begin
      if (src.size() == 0) begin
        b = ($urandom_range(0, 2) == 0) ? 8'h5A : 8'($urandom);
        for (int k = 7; k >= 0; k--) src.push_back(b[k]);
      end
      r = ($urandom_range(0, 299) == 0);
      v = ($urandom_range(0, 3) != 0);
      s = v ? src.pop_front() : 1'($urandom_range(0, 1));
      step(r, v, s);
      n_cmp++;
      if (got_a !== exp_vec(0)) begin n_bad++; $display("FAIL rand_model_a c=%0d: got %h exp %h", c, got_a, exp_vec(0)); end
      n_cmp++;
      if (got_b !== exp_vec(1)) begin n_bad++; $display("FAIL rand_model_b c=%0d: got %h exp %h", c, got_b, exp_vec(1)); end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_overlap();
    test_gated();
    test_mid_reset();
    test_lsb12();
    test_relock();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_word_deserializer.md
# sync_word_deserializer

Parametrised serial-to-parallel converter gated by a programmable sync word. It hunts a qualified serial bit stream for `SYNC_WORD`, locks, then deserialises exactly `FRAME_WORDS` words of `DATA_W` bits each, and drops back to hunting. It sits between the serial line receiver and the parallel datapath and is the successor of the fixed 0x5A start-code detector.

## Interface
- `SYNC_W`, default 8: sync word width in bits (≥2).
- `SYNC_WORD`, default 8'h5A: pattern that arms conversion; compared MSB-first (first received bit = bit `SYNC_W-1`).
- `DATA_W`, default 8: parallel word width (≥2).
- `FRAME_WORDS`, default 4: data words per frame after each sync (≥1).
- `MSB_FIRST`, default 1: 1 = first data bit lands in `P_OUT[DATA_W-1]`; 0 = first bit lands in `P_OUT[0]`.
- `CLK` in 1: clock; all logic is on the rising edge.
- `RESET` in 1: synchronous, active-high.
- `S_IN` in 1: serial data bit.
- `S_VALID` in 1: `S_IN` is sampled only on edges where this is 1.
- `P_OUT` out `DATA_W`: last completed word; holds until the next word completes.
- `P_VALID` out 1: one-cycle pulse when `P_OUT` updates.
- `FRAME_START` out 1: coincides with `P_VALID` of word 0 of a frame.
- `FRAME_END` out 1: coincides with `P_VALID` of word `FRAME_WORDS-1`.
- `LOCKED` out 1: high while in COLLECT.

## Operation
- States: HUNT, COLLECT. The reset state is HUNT.
- **HUNT**
  - Each qualified bit shifts into the `SYNC_W`-bit history register (new bit enters at LSB).
  - A fill counter saturates at `SYNC_W`.
  - A match requires fill = `SYNC_W` after the shift and history-after-shift == `SYNC_WORD`. Zeros left from reset never match.
  - On a match: go to COLLECT, clear the bit and word counters.
  - Overlapping patterns are detected: a failed partial match does not flush the history.
- **COLLECT**
  - Each qualified bit goes into the data shift register, per `MSB_FIRST`.
  - When the bit counter reaches `DATA_W-1` and a qualified bit arrives:
    - load `P_OUT`, pulse `P_VALID`;
    - pulse `FRAME_START` if word count = 0;
    - pulse `FRAME_END` if word count = `FRAME_WORDS-1`;
    - reset the bit counter and increment the word counter.
- After the `FRAME_END` word: return to HUNT with the fill counter cleared. A complete new sync word is required, and data bits are never reused as sync bits.
- `FRAME_WORDS`=1: `FRAME_START` and `FRAME_END` pulse in the same cycle.
- `S_VALID`=0: no state, counter or register changes. All pulses are 0.
- Bits received in COLLECT are never compared against `SYNC_WORD`.
- Counter widths:
  - bit counter `$clog2(DATA_W)`;
  - word counter `$clog2(FRAME_WORDS)` (minimum 1);
  - fill counter `$clog2(SYNC_W+1)`.
- **RESET asserted** (at any time, including mid-frame):
  - next edge forces HUNT;
  - clears history, fill, bit, word and data registers;
  - `P_OUT`=0, `P_VALID`=`FRAME_START`=`FRAME_END`=`LOCKED`=0;
  - a partial frame is discarded with no `FRAME_END`;
  - `RESET` has priority over `S_VALID`.

## Timing
- All outputs are registered. Reset values are all 0.
- Lock: the last sync bit is sampled at edge k, so `LOCKED`=1 from edge k.
- Word: the `DATA_W`-th data bit is sampled at edge m, so `P_OUT`/`P_VALID` update at edge m, with one-cycle latency from the last bit. `P_VALID` falls at edge m+1 unless another word completes (impossible for `DATA_W`≥2).
- The first data bit may be sampled at edge k+1 (back-to-back with the sync word). No dead cycles are required.
- Unlock: `LOCKED` falls at the edge after the `FRAME_END` edge. The next sync bit may be sampled on that same edge (it counts as fill bit 1).
- Maximum throughput: one bit per cycle. There is no backpressure, and the downstream must accept every `P_VALID`.

## Structure
- Package `ser_par_pkg`:
  - state encoding constants `ST_HUNT`, `ST_COLLECT`;
  - a `clog2`-safe width helper;
  - default `SYNC_WORD` constant 8'h5A, shared with the legacy block.
- Sub-module `sync_word_matcher`:
  - contents: history shift register, fill counter and comparator;
  - ports: `CLK`, `RESET`, `clear`, `bit_in`, `bit_en`, `match`.
  - `match` is combinational on the shifted value so lock costs no extra cycle.
- The top level holds the FSM, counters, data shift register and output registers.

## Test plan
- **Default params, back-to-back stream.** Stimulus: 0x5A then 0x11, 0x22, 0x33, 0x44 at one bit per cycle. Required: `LOCKED` at the 8th bit; four `P_VALID` pulses 8 cycles apart with `P_OUT` = 11, 22, 33, 44; `FRAME_START` on 0x11; `FRAME_END` on 0x44; `LOCKED` low after.
- **Prefix and overlap.** Stimulus: 10 ones then bits 0101_1010 preceded by 0101. Required: exactly one lock, at the final 0 of 0x5A; no lock on reset zeros.
- **Gated input.** Same frame with `S_VALID` toggling 1,0,0,1… Required: identical `P_OUT` sequence; pulses only on qualifying edges; outputs frozen on `S_VALID`=0.
- **Mid-frame reset.** Assert `RESET` after word 1 (0x22) for 1 cycle, then send 0x33 with no sync. Required: all outputs 0; no `P_VALID`; no `FRAME_END`.
- **`MSB_FIRST`=0, `FRAME_WORDS`=1, `DATA_W`=12.** Stimulus: sync, then bits of 0xABC LSB-first. Required: `P_OUT`=0xABC with `P_VALID`, `FRAME_START` and `FRAME_END` all in the same cycle.
- **Post-frame relock.** Stimulus: frame ending in data 0x5A, followed by 0x00. Required: no lock from the data bits; relock only after a fresh 0x5A is sent.
